// File: rtl/noc_vc_input_buffer.sv
// noc_vc_input_buffer
// Per-VC credit-based input buffer for a NoC router port. Flits are queued in
// one circular FIFO per virtual channel. One VC at a time is presented
// downstream (first-word fall-through), with wormhole locking on multi-flit
// packets and round-robin between packets. A pop returns a registered
// one-cycle credit pulse on the VC it came from.
module noc_vc_input_buffer #(
    parameter int NUM_VC            = 2,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int VC_WIDTH          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                          clk_noc,
    input  logic                          rst_n,
    input  logic [FLIT_WIDTH-1:0]         data_in,
    input  logic [DEST_WIDTH-1:0]         dest_in,
    input  logic                          is_tail_in,
    input  logic                          send_in,
    input  logic [VC_WIDTH-1:0]           vc_in,
    output logic [NUM_VC-1:0]             credit_out,
    output logic [FLIT_WIDTH-1:0]         data_out,
    output logic [DEST_WIDTH-1:0]         dest_out,
    output logic                          is_tail_out,
    output logic [VC_WIDTH-1:0]           vc_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [NUM_VC*CNT_WIDTH-1:0]   occupancy,
    output logic                          overflow_err
);

    localparam int PTR_WIDTH   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int ENTRY_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [VC_WIDTH-1:0]  LAST_VC  = VC_WIDTH'(NUM_VC - 1);

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Storage entry layout: {data, dest, is_tail}
    logic [ENTRY_WIDTH-1:0] mem_r    [NUM_VC][FLIT_BUFFER_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r [NUM_VC];
    logic [PTR_WIDTH-1:0]   rd_ptr_r [NUM_VC];
    logic [CNT_WIDTH-1:0]   cnt_r    [NUM_VC];

    arb_state_t             state_r;
    arb_state_t             state_nxt_s;
    logic [VC_WIDTH-1:0]    lock_vc_r;
    logic [VC_WIDTH-1:0]    lock_vc_nxt_s;
    logic [VC_WIDTH-1:0]    rr_ptr_r;
    logic [VC_WIDTH-1:0]    rr_ptr_nxt_s;
    logic [VC_WIDTH-1:0]    grant_vc_r;
    logic                   hold_r;

    logic [VC_WIDTH-1:0]    sel_vc_s;
    logic                   sel_valid_s;
    logic [ENTRY_WIDTH-1:0] head_s;
    logic                   pop_any_s;
    logic                   vc_in_ok_s;
    logic                   overflow_set_s;
    logic [NUM_VC-1:0]      nonempty_s;
    logic [NUM_VC-1:0]      full_s;
    logic [NUM_VC-1:0]      push_s;
    logic [NUM_VC-1:0]      pop_s;
    logic [NUM_VC-1:0]      credit_r;
    logic                   overflow_r;

    // Circular pointer advance that also wraps for non-power-of-two depths
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        logic [PTR_WIDTH-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_WIDTH'(1);
        end
        return nxt;
    endfunction

    // Per-VC status flags and range check on the incoming VC index
    always_comb begin
        nonempty_s = '0;
        full_s     = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            nonempty_s[v] = (cnt_r[v] != '0);
            full_s[v]     = (cnt_r[v] == FULL_CNT);
        end
        vc_in_ok_s = (32'(vc_in) < 32'(NUM_VC));
    end

    // Grant selection: locked VC, else held grant while stalled, else round-robin scan
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        sel_vc_s    = grant_vc_r;
        sel_valid_s = 1'b0;
        case (state_r)
            ARB_LOCKED: begin
                sel_vc_s    = lock_vc_r;
                sel_valid_s = nonempty_s[lock_vc_r];
            end
            ARB_IDLE: begin
                if (hold_r) begin
                    // Presented flit was not taken: keep the same VC on the output
                    sel_vc_s    = grant_vc_r;
                    sel_valid_s = nonempty_s[grant_vc_r];
                end else begin
                    for (int i = 1; i <= NUM_VC; i++) begin
                        idx = int'(rr_ptr_r) + i;
                        if (idx >= NUM_VC) begin
                            idx = idx - NUM_VC;
                        end else begin
                            idx = idx;
                        end
                        if (!found && nonempty_s[idx]) begin
                            found    = 1'b1;
                            sel_vc_s = VC_WIDTH'(idx);
                        end else begin
                            found    = found;
                        end
                    end
                    sel_valid_s = found;
                end
            end
            default: begin
                sel_vc_s    = grant_vc_r;
                sel_valid_s = 1'b0;
            end
        endcase
    end

    assign head_s    = mem_r[sel_vc_s][rd_ptr_r[sel_vc_s]];
    assign pop_any_s = sel_valid_s & ready_in;

    // Push/pop decode; a full VC still accepts a push when its head leaves this cycle
    always_comb begin
        pop_s  = '0;
        push_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pop_s[v]  = pop_any_s && (sel_vc_s == VC_WIDTH'(v));
            push_s[v] = send_in && vc_in_ok_s && (vc_in == VC_WIDTH'(v))
                        && (!full_s[v] || pop_s[v]);
        end
        overflow_set_s = send_in && (push_s == '0);
    end

    // Arbitration next state: non-tail pop locks, tail pop unlocks and moves rr_ptr
    always_comb begin
        state_nxt_s   = state_r;
        lock_vc_nxt_s = lock_vc_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        if (pop_any_s) begin
            if (head_s[0]) begin
                state_nxt_s  = ARB_IDLE;
                rr_ptr_nxt_s = sel_vc_s;
            end else begin
                state_nxt_s   = ARB_LOCKED;
                lock_vc_nxt_s = sel_vc_s;
            end
        end else begin
            state_nxt_s   = state_r;
            lock_vc_nxt_s = lock_vc_r;
        end
    end

    // Arbitration state, grant memory and round-robin pointer (VC0 first after reset)
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_IDLE;
            lock_vc_r  <= '0;
            rr_ptr_r   <= LAST_VC;
            grant_vc_r <= '0;
            hold_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_vc_r  <= lock_vc_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            grant_vc_r <= sel_vc_s;
            hold_r     <= sel_valid_s & ~ready_in;
        end
    end

    // FIFO pointers and occupancy counters per VC
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_r[v] <= '0;
                rd_ptr_r[v] <= '0;
                cnt_r[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_s[v]) begin
                    wr_ptr_r[v] <= next_ptr(wr_ptr_r[v]);
                end
                if (pop_s[v]) begin
                    rd_ptr_r[v] <= next_ptr(rd_ptr_r[v]);
                end
                if (push_s[v] && !pop_s[v]) begin
                    cnt_r[v] <= cnt_r[v] + CNT_WIDTH'(1);
                end else if (pop_s[v] && !push_s[v]) begin
                    cnt_r[v] <= cnt_r[v] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // FIFO storage write; contents need no reset since empty FIFOs are never presented
    always_ff @(posedge clk_noc) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_s[v]) begin
                mem_r[v][wr_ptr_r[v]] <= {data_in, dest_in, is_tail_in};
            end
        end
    end

    // Registered credit pulses and sticky overflow flag
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            credit_r   <= pop_s;
            overflow_r <= overflow_r | overflow_set_s;
        end
    end

    // Output presentation; payload fields read as zero whenever nothing is presented
    always_comb begin
        valid_out = sel_valid_s;
        if (sel_valid_s) begin
            {data_out, dest_out, is_tail_out} = head_s;
            vc_out = sel_vc_s;
        end else begin
            data_out    = '0;
            dest_out    = '0;
            is_tail_out = 1'b0;
            vc_out      = '0;
        end
        occupancy = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occupancy[v*CNT_WIDTH +: CNT_WIDTH] = cnt_r[v];
        end
    end

    assign credit_out   = credit_r;
    assign overflow_err = overflow_r;

endmodule
